bnn_param_loader: RTL and testbench

Drives the serial parameter chain of the binary neuron array. It accepts parallel `{bias, weights}` frames over a valid/ready handshake and serializes them onto the chain's `setup`/`param` lines. While shifting, it captures the bits falling out of the last neuron's `param_out` and returns the previous chain contents as parallel frames. It also has a non-destructive readback mode that recirculates the chain onto itself. It sits between the host/config interface and the first neuron's `param_in`.

---
 rtl/bnn_pkg.sv | 13 +
 rtl/param_frame_shreg.sv | 49 ++++
 rtl/bnn_param_loader.sv | 94 +++++++++
 tb/tb_bnn_param_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared state encoding, default sizes and frame-width helper for the neuron parameter loader
package bnn_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    localparam int DEF_INPUTS    = 8;
    localparam int DEF_BIAS_BITS = 3;

    function automatic int frame_bits(input int inputs, input int bias_bits);
        return inputs + bias_bits;
    endfunction

endpackage

// File: rtl/param_frame_shreg.sv
// param_frame_shreg: MSB-first frame serializer toward the chain, LSB-in capture of the displaced frame, per-frame bit counter
module param_frame_shreg #(
    parameter int  FRAME_BITS = 11,
    localparam int CW         = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1,
    localparam int SW         = FRAME_BITS - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] load_word,
    input  logic                  shift,
    input  logic                  ser_in,
    output logic                  ser_out,
    output logic                  frame_end,
    output logic [FRAME_BITS-1:0] rd_word,
    output logic                  rd_valid
);

    logic [FRAME_BITS-1:0] piso;
    logic [SW-1:0]         sipo;
    logic [CW-1:0]         bit_cnt;

    assign ser_out   = piso[FRAME_BITS-1];
    assign frame_end = shift && (bit_cnt == CW'(FRAME_BITS - 1));

    // shift out MSB first, capture into LSB, publish the captured frame once its last bit is in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            piso     <= '0;
            sipo     <= '0;
            bit_cnt  <= '0;
            rd_word  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= frame_end;
            if (load)
                piso <= load_word;
            else if (shift)
                piso <= piso << 1;
            if (shift) begin
                sipo    <= SW'({sipo, ser_in});
                bit_cnt <= frame_end ? '0 : bit_cnt + 1'b1;
            end
            if (frame_end)
                rd_word <= {sipo, ser_in};
        end
    end

endmodule

// File: rtl/bnn_param_loader.sv
// bnn_param_loader: serializes {bias, weights} frames into the neuron chain and returns the frames it displaces
module bnn_param_loader
    import bnn_pkg::*;
#(
    parameter int  INPUTS     = DEF_INPUTS,
    parameter int  BIAS_BITS  = DEF_BIAS_BITS,
    parameter int  NEURONS    = 4,
    localparam int FRAME_BITS = frame_bits(INPUTS, BIAS_BITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  recirc,
    input  logic [FRAME_BITS-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  setup,
    output logic                  param,
    input  logic                  chain_in,
    output logic [FRAME_BITS-1:0] rd_word,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int FW = (NEURONS > 1) ? $clog2(NEURONS) : 1;

    state_t        state;
    logic          mode;
    logic [FW-1:0] frame_cnt;
    logic          shreg_out;
    logic          frame_end;
    logic          load;

    assign word_ready = (state == FETCH);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign load       = word_ready && word_valid;
    // recirculation feeds the chain's own output straight back so its contents survive the pass
    assign param      = mode ? chain_in : shreg_out;

    param_frame_shreg #(.FRAME_BITS(FRAME_BITS)) u_shreg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_word (word_in),
        .shift     (setup),
        .ser_in    (chain_in),
        .ser_out   (shreg_out),
        .frame_end (frame_end),
        .rd_word   (rd_word),
        .rd_valid  (rd_valid)
    );

    // sequencing: fetch then shift per frame in load mode, one unbroken shift run in recirc mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mode      <= 1'b0;
            frame_cnt <= '0;
            setup     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode      <= recirc;
                    frame_cnt <= '0;
                    setup     <= recirc;
                    state     <= recirc ? SHIFT : FETCH;
                end
                FETCH: if (word_valid) begin
                    setup <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: if (frame_end) begin
                    if (frame_cnt == FW'(NEURONS - 1)) begin
                        setup <= 1'b0;
                        state <= DONE;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                        if (!mode) begin
                            setup <= 1'b0;
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    mode  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_param_loader.sv
// tb_bnn_param_loader: loader driven against a two-neuron chain model, table rows plus reset and random sequences
module tb_bnn_param_loader;

    localparam int IN = 8;
    localparam int BB = 3;
    localparam int N  = 2;
    localparam int FB = 11;

    typedef struct {
        logic          recirc;
        logic [FB-1:0] f0;
        logic [FB-1:0] f1;
        int            gap;
        logic          noise;
        logic [FB-1:0] e0;
        logic [FB-1:0] e1;
        logic [FB-1:0] c1;
        logic [FB-1:0] c0;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          recirc = 1'b0;
    logic          word_valid = 1'b0;
    logic [FB-1:0] word_in = '0;
    logic          word_ready, setup, param, chain_in, rd_valid, busy, done;
    logic [FB-1:0] rd_word;
    logic [FB-1:0] chain [N];

    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            run = 0;
    logic          done_rd = 1'b0;
    logic [FB-1:0] rdq [$];
    int            runs [$];

    bnn_param_loader #(.INPUTS(IN), .BIAS_BITS(BB), .NEURONS(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .recirc     (recirc),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .setup      (setup),
        .param      (param),
        .chain_in   (chain_in),
        .rd_word    (rd_word),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign chain_in = chain[N-1][FB-1];

    // neuron chain: every setup edge moves each neuron's frame left, neuron 0 takes param
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (setup) begin
            chain[0] <= {chain[0][FB-2:0], param};
            for (int i = 1; i < N; i++)
                chain[i] <= {chain[i][FB-2:0], chain[i-1][FB-1]};
        end
    end

    // observe pulses, returned frames and setup run lengths mid-cycle
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_rd  = rd_valid;
        end
        if (rd_valid)
            rdq.push_back(rd_word);
        if (setup)
            run++;
        else if (run > 0) begin
            runs.push_back(run);
            run = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic r, input logic [FB-1:0] f0, input logic [FB-1:0] f1,
                         input int gap, input logic noise,
                         input logic [FB-1:0] e0, input logic [FB-1:0] e1,
                         input logic [FB-1:0] c1, input logic [FB-1:0] c0);
        logic [FB-1:0] fr [2];
        int s;
        int n;
        fr[0] = f0;
        fr[1] = f1;
        rdq.delete();
        runs.delete();
        run = 0;
        done_cnt = 0;
        done_cyc = 0;
        done_rd = 1'b0;
        if (noise) begin
            word_valid = 1'b1;
            word_in = 11'h3C3;
            repeat (3) begin
                @(negedge clk);
                check("idle_ready", word_ready, 0);
                check("idle_busy", busy, 0);
            end
        end
        @(negedge clk);
        start = 1'b1;
        recirc = r;
        @(negedge clk);
        start = 1'b0;
        recirc = 1'b0;
        s = cyc;
        check("busy_after_start", busy, 1);
        if (!r) begin
            for (int i = 0; i < N; i++) begin
                n = 0;
                while (!word_ready && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("fetch_reached", n < 100, 1);
                for (int g = 0; i > 0 && g < gap; g++) begin
                    check("stall_setup", setup, 0);
                    check("stall_ready", word_ready, 1);
                    @(negedge clk);
                end
                word_in = fr[i];
                word_valid = 1'b1;
                @(negedge clk);
                word_valid = 1'b0;
                if (i == 0 && noise) begin
                    start = 1'b1;
                    recirc = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    recirc = 1'b0;
                end
            end
        end
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        word_valid = 1'b0;
        check("done_pulses", done_cnt, 1);
        check("latency", done_cyc - s, r ? N * FB : N * (FB + 1) + gap);
        check("done_with_rd", done_rd, 1);
        check("rd_count", rdq.size(), N);
        check("rd0", rdq.size() > 0 ? {21'd0, rdq[0]} : 32'hFFFF_FFFF, e0);
        check("rd1", rdq.size() > 1 ? {21'd0, rdq[1]} : 32'hFFFF_FFFF, e1);
        check("setup_runs", runs.size(), r ? 1 : N);
        foreach (runs[k])
            check("setup_len", runs[k], r ? N * FB : FB);
        check("chain_last", chain[N-1], c1);
        check("chain_first", chain[0], c0);
        check("idle_after", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [5];
        logic [FB-1:0] m1;
        logic [FB-1:0] m0;
        for (int i = 0; i < N; i++)
            chain[i] = '0;
        tbl[0] = '{1'b0, 11'h5A3, 11'h2C1, 0, 1'b0, 11'h000, 11'h000, 11'h5A3, 11'h2C1};
        tbl[1] = '{1'b1, 11'h000, 11'h000, 0, 1'b0, 11'h5A3, 11'h2C1, 11'h5A3, 11'h2C1};
        tbl[2] = '{1'b0, 11'h5A3, 11'h2C1, 5, 1'b0, 11'h5A3, 11'h2C1, 11'h5A3, 11'h2C1};
        tbl[3] = '{1'b0, 11'h123, 11'h456, 0, 1'b1, 11'h5A3, 11'h2C1, 11'h123, 11'h456};
        tbl[4] = '{1'b1, 11'h000, 11'h000, 0, 1'b0, 11'h123, 11'h456, 11'h123, 11'h456};

        repeat (3) @(negedge clk);
        check("rst_outputs", {setup, param, word_ready, rd_valid, busy, done}, 0);
        check("rst_rd_word", rd_word, 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (tbl[i])
            do_op(tbl[i].recirc, tbl[i].f0, tbl[i].f1, tbl[i].gap, tbl[i].noise,
                  tbl[i].e0, tbl[i].e1, tbl[i].c1, tbl[i].c0);

        @(negedge clk);
        start = 1'b1;
        recirc = 1'b0;
        @(negedge clk);
        start = 1'b0;
        word_in = 11'h6B5;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_reset_setup", setup, 1);
        reset = 1'b1;
        #1;
        check("midrst_outputs", {setup, param, word_ready, rd_valid, busy, done}, 0);
        check("midrst_rd_word", rd_word, 0);
        @(negedge clk);
        reset = 1'b0;
        m1 = chain[N-1];
        m0 = chain[0];
        do_op(1'b0, 11'h7FF, 11'h000, 0, 1'b0, m1, m0, 11'h7FF, 11'h000);

        m1 = 11'h7FF;
        m0 = 11'h000;
        for (int k = 0; k < 8; k++) begin
            logic          r;
            logic [FB-1:0] a;
            logic [FB-1:0] b;
            int            g;
            r = 1'($urandom_range(0, 1));
            a = FB'($urandom);
            b = FB'($urandom);
            g = int'($urandom_range(0, 3));
            do_op(r, a, b, g, k[0], m1, m0, r ? m1 : a, r ? m0 : b);
            if (!r) begin
                m1 = a;
                m0 = b;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
